// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI command controller: opcodes, response tags,
// FSM state encoding and the response-word builder.
package spi_ctrl_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_READ   = 4'h2;
    localparam logic [3:0] OP_STATUS = 4'h3;

    localparam logic [3:0] TAG_WRITE   = 4'h1;
    localparam logic [3:0] TAG_READ    = 4'h2;
    localparam logic [3:0] TAG_STATUS  = 4'h3;
    localparam logic [3:0] TAG_ILLEGAL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DECODE  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_LOAD    = 3'd4
    } state_e;

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_STATUS;
    endfunction

    function automatic logic [31:0] build_resp(
        input logic [3:0]  op,
        input logic [3:0]  addr,
        input logic [23:0] wdata,
        input logic [23:0] rdata,
        input logic        overrun,
        input logic        illegal,
        input logic [7:0]  cnt8
    );
        case (op)
            OP_NOP:    return 32'h0;
            OP_WRITE:  return {TAG_WRITE, addr, wdata};
            OP_READ:   return {TAG_READ, addr, rdata};
            OP_STATUS: return {TAG_STATUS, 18'h0, overrun, illegal, cnt8};
            default:   return {TAG_ILLEGAL, 28'h0};
        endcase
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Bundle of SPI shifter and register-file signals around the command controller.
interface spi_cmd_ctrl_if;

    logic        ss_n;
    logic [31:0] spi_data_out;
    logic [31:0] spi_data_in;
    logic        spi_data_valid_n;
    logic        spi_enable_sn;
    logic [3:0]  reg_addr;
    logic [23:0] reg_wdata;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [23:0] reg_rdata;
    logic        busy;

    // master: the controller; slave: the SPI shifter plus register file around it
    modport master (
        input  ss_n, spi_data_out, reg_rdata,
        output spi_data_in, spi_data_valid_n, spi_enable_sn,
               reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy
    );

    modport slave (
        output ss_n, spi_data_out, reg_rdata,
        input  spi_data_in, spi_data_valid_n, spi_enable_sn,
               reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for the raw slave select with edge detection on the
// two settled stages (bit 2 is the older sample).
module spi_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic d_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_in};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = (sync_q[2:1] == 2'b01);
    assign fall  = (sync_q[2:1] == 2'b10);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes a captured 32-bit command at the end of each
// frame, strobes the register file and loads a response word into the shifter.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int FRAME_CNT_W = 8,
    parameter int LOAD_HOLD   = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    spi_cmd_ctrl_if.master bus
);

    localparam int HOLD_W = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;

    logic ss_level, ss_rise, ss_fall;
    logic unused_level;

    spi_sync_edge u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d_in    (bus.ss_n),
        .level   (ss_level),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    assign unused_level = ss_level;

    state_e                 state_q, state_d;
    logic [3:0]             op_q, op_d;
    logic [3:0]             addr_q, addr_d;
    logic [23:0]            wdata_q, wdata_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   illegal_q, illegal_d;
    logic                   overrun_q, overrun_d;
    logic [31:0]            din_q, din_d;
    logic                   valid_n_q, valid_n_d;
    logic                   enable_sn_q, enable_sn_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rd_en_q, rd_en_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   abort;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        frame_cnt_d = frame_cnt_q;
        illegal_d   = illegal_q;
        overrun_d   = overrun_q;
        din_d       = din_q;
        valid_n_d   = 1'b1;
        enable_sn_d = 1'b0;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        hold_d      = hold_q;
        abort       = ss_fall && (state_q != ST_IDLE);

        // Capture, counting and illegal flagging stand even if this frame is aborted
        if (state_q == ST_CAPTURE) begin
            op_d        = bus.spi_data_out[31:28];
            addr_d      = bus.spi_data_out[27:24];
            wdata_d     = bus.spi_data_out[23:0];
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            if (is_illegal(op_d)) begin
                illegal_d = 1'b1;
            end
        end

        if (abort) begin
            state_d   = ST_IDLE;
            overrun_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_rise) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_d = ST_DECODE;
                    wr_en_d = (op_d == OP_WRITE);
                    rd_en_d = (op_d == OP_READ);
                end
                ST_DECODE: begin
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // Flags are sampled into the word before a STATUS clears them
                    din_d = build_resp(op_q, addr_q, wdata_q, bus.reg_rdata,
                                       overrun_q, illegal_q, 8'(frame_cnt_q));
                    if (op_q == OP_STATUS) begin
                        illegal_d = 1'b0;
                        overrun_d = 1'b0;
                    end
                    valid_n_d = 1'b0;
                    hold_d    = '0;
                    state_d   = ST_LOAD;
                end
                ST_LOAD: begin
                    if (hold_q == HOLD_W'(LOAD_HOLD - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d    = hold_q + HOLD_W'(1);
                        valid_n_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            frame_cnt_q <= '0;
            illegal_q   <= 1'b0;
            overrun_q   <= 1'b0;
            din_q       <= '0;
            valid_n_q   <= 1'b1;
            enable_sn_q <= 1'b1;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            frame_cnt_q <= frame_cnt_d;
            illegal_q   <= illegal_d;
            overrun_q   <= overrun_d;
            din_q       <= din_d;
            valid_n_q   <= valid_n_d;
            enable_sn_q <= enable_sn_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.spi_data_in      = din_q;
    assign bus.spi_data_valid_n = valid_n_q;
    assign bus.spi_enable_sn    = enable_sn_q;
    assign bus.reg_addr         = addr_q;
    assign bus.reg_wdata        = wdata_q;
    assign bus.reg_wr_en        = wr_en_q;
    assign bus.reg_rd_en        = rd_en_q;
    assign bus.busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: a frame-timeline model (phase = cycles since the
// synchronized frame end) checked every cycle, plus literal frame checks.
module tb_spi_cmd_ctrl;

    localparam int H = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_ctrl_if bus ();

    spi_cmd_ctrl #(.FRAME_CNT_W(8), .LOAD_HOLD(H)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit rand_rd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase -1 means idle, otherwise cycles elapsed since the frame-end cycle
    int          m_phase;
    int          m_cnt;
    logic [3:0]  m_op;
    logic        m_ill, m_ovr;
    logic [2:0]  m_sync;
    logic [31:0] e_din;
    logic        e_vn, e_en, e_wr, e_rd;
    logic [3:0]  e_addr;
    logic [23:0] e_wdata;
    logic        m_rise, m_fall;
    logic [3:0]  op_in;

    assign m_rise = (m_sync[2:1] == 2'b01);
    assign m_fall = (m_sync[2:1] == 2'b10);
    assign op_in  = bus.spi_data_out[31:28];

    function automatic logic [31:0] model_resp(input logic [3:0] op, input logic [3:0] a,
                                               input logic [23:0] wd, input logic [23:0] rd,
                                               input logic ovr, input logic ill, input int cnt);
        if (op == 4'd0) return 32'h0;
        if (op == 4'd1) return {4'h1, a, wd};
        if (op == 4'd2) return {4'h2, a, rd};
        if (op == 4'd3) return {4'h3, 18'h0, ovr, ill, 8'(cnt)};
        return 32'hF000_0000;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sync <= 3'b111; m_phase <= -1; m_cnt <= 0; m_op <= 4'h0;
            m_ill <= 1'b0; m_ovr <= 1'b0; e_din <= 32'h0; e_vn <= 1'b1; e_en <= 1'b1;
            e_wr <= 1'b0; e_rd <= 1'b0; e_addr <= 4'h0; e_wdata <= 24'h0;
        end else begin
            m_sync <= {m_sync[1:0], bus.ss_n};
            e_en <= 1'b0; e_wr <= 1'b0; e_rd <= 1'b0; e_vn <= 1'b1;
            if (m_phase == 1) begin
                m_op    <= op_in;
                e_addr  <= bus.spi_data_out[27:24];
                e_wdata <= bus.spi_data_out[23:0];
                m_cnt   <= (m_cnt + 1) % 256;
                if (op_in >= 4'd4) m_ill <= 1'b1;
            end
            if (m_phase < 0) begin
                if (m_rise) m_phase <= 1;
            end else if (m_fall) begin
                m_phase <= -1;
                m_ovr   <= 1'b1;
            end else begin
                if (m_phase == 1) begin
                    e_wr <= (op_in == 4'd1);
                    e_rd <= (op_in == 4'd2);
                end
                if (m_phase == 3) begin
                    e_din <= model_resp(m_op, e_addr, e_wdata, bus.reg_rdata, m_ovr, m_ill, m_cnt);
                    if (m_op == 4'd3) begin
                        m_ill <= 1'b0;
                        m_ovr <= 1'b0;
                    end
                end
                if (m_phase >= 3 && m_phase < 3 + H) e_vn <= 1'b0;
                m_phase <= (m_phase == 3 + H) ? -1 : m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("spi_data_in", bus.spi_data_in, e_din);
            chk("valid_n", 32'(bus.spi_data_valid_n), 32'(e_vn));
            chk("enable_sn", 32'(bus.spi_enable_sn), 32'(e_en));
            chk("reg_addr", 32'(bus.reg_addr), 32'(e_addr));
            chk("reg_wdata", 32'(bus.reg_wdata), 32'(e_wdata));
            chk("reg_wr_en", 32'(bus.reg_wr_en), 32'(e_wr));
            chk("reg_rd_en", 32'(bus.reg_rd_en), 32'(e_rd));
            chk("busy", 32'(bus.busy), 32'(m_phase >= 0));
        end
    end

    logic [31:0] obs_din[16];
    logic        obs_vn[16], obs_wr[16], obs_rd[16], obs_busy[16];
    logic [3:0]  obs_addr[16];
    logic [23:0] obs_wdata[16];

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rd) bus.reg_rdata = 24'($urandom());
    endtask

    // obs[j] holds outputs in the j-th cycle after ss_n was driven high
    task automatic frame(input logic [31:0] w, input int low_cyc, input int high_cyc, input int abort_at);
        bus.spi_data_out = w;
        bus.ss_n = 1'b0;
        repeat (low_cyc) tick();
        bus.ss_n = 1'b1;
        for (int j = 1; j <= high_cyc; j++) begin
            tick();
            obs_din[j] = bus.spi_data_in;   obs_vn[j]   = bus.spi_data_valid_n;
            obs_wr[j]  = bus.reg_wr_en;     obs_rd[j]   = bus.reg_rd_en;
            obs_busy[j] = bus.busy;         obs_addr[j] = bus.reg_addr;
            obs_wdata[j] = bus.reg_wdata;
            if (j == abort_at) bus.ss_n = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] w;
        int ab;
        bus.ss_n = 1'b1;
        bus.spi_data_out = 32'h0;
        bus.reg_rdata = 24'h0;
        tick();
        chk_en = 1'b1;
        chk("rst_valid_n", 32'(bus.spi_data_valid_n), 32'd1);
        chk("rst_enable_sn", 32'(bus.spi_enable_sn), 32'd1);
        chk("rst_din", bus.spi_data_in, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("enable_after_rst", 32'(bus.spi_enable_sn), 32'd0);

        frame(32'h7000_0000, 2, 9, 0);
        chk("illegal_resp", obs_din[6], 32'hF000_0000);
        chk("illegal_vn", 32'(obs_vn[6]), 32'd0);
        frame(32'h3000_0000, 2, 9, 0);
        chk("status_ill", obs_din[6], 32'h3000_0102);
        frame(32'h3000_0000, 2, 9, 0);
        chk("status_clr", obs_din[6], 32'h3000_0003);

        frame(32'h15AB_CDEF, 2, 9, 0);
        chk("wr_pre", 32'(obs_wr[3]), 32'd0);
        chk("wr_pulse", 32'(obs_wr[4]), 32'd1);
        chk("wr_post", 32'(obs_wr[5]), 32'd0);
        chk("wr_addr", 32'(obs_addr[4]), 32'd5);
        chk("wr_wdata", 32'(obs_wdata[4]), 32'h00AB_CDEF);
        chk("wr_resp", obs_din[6], 32'h15AB_CDEF);
        chk("wr_vn5", 32'(obs_vn[5]), 32'd1);
        chk("wr_vn6", 32'(obs_vn[6]), 32'd0);
        chk("wr_vn7", 32'(obs_vn[7]), 32'd0);
        chk("wr_vn8", 32'(obs_vn[8]), 32'd1);
        chk("model_wr_resp", e_din, 32'h15AB_CDEF);

        bus.reg_rdata = 24'h123456;
        frame(32'h2300_0000, 2, 9, 0);
        chk("rd_pulse", 32'(obs_rd[4]), 32'd1);
        chk("rd_post", 32'(obs_rd[5]), 32'd0);
        chk("rd_resp", obs_din[6], 32'h2312_3456);

        frame(32'h1900_0055, 2, 8, 3);
        chk("abort_wr_kept", 32'(obs_wr[4]), 32'd1);
        chk("abort_busy5", 32'(obs_busy[5]), 32'd1);
        chk("abort_busy6", 32'(obs_busy[6]), 32'd0);
        for (int j = 4; j <= 8; j++) chk("abort_vn", 32'(obs_vn[j]), 32'd1);
        chk("abort_din_kept", obs_din[8], 32'h2312_3456);
        frame(32'h3000_0000, 2, 9, 0);
        chk("status_ovr", obs_din[6], 32'h3000_0207);
        chk("model_ovr_clr", 32'(m_ovr), 32'd0);

        rand_rd = 1'b1;
        for (int f = 0; f < 80; f++) begin
            w = $urandom();
            if ($urandom_range(0, 3) != 0) w[31:28] = 4'($urandom_range(0, 3));
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
            frame(w, $urandom_range(1, 3), (ab != 0) ? 8 : $urandom_range(1, 10), ab);
        end
        bus.ss_n = 1'b1;
        repeat (12) tick();

        frame(32'h1234_5678, 2, 6, 0);
        chk("load_vn", 32'(obs_vn[6]), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("rst_load_vn", 32'(bus.spi_data_valid_n), 32'd1);
        chk("rst_load_en", 32'(bus.spi_enable_sn), 32'd1);
        chk("rst_load_wr", 32'(bus.reg_wr_en), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        for (int f = 0; f < 256; f++) frame(32'h0000_0000, 1, 9, 0);
        chk("model_wrap", 32'(m_cnt), 32'd0);
        frame(32'h3000_0000, 2, 9, 0);
        chk("status_wrap", obs_din[6], 32'h3000_0001);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
